// File: rtl/gshare_assoc_predictor_if.sv
// Fetch/execute-side bundle for the gshare associative direction predictor.
// The master drives lookups and resolved updates; the slave is the predictor itself.
interface gshare_assoc_predictor_if #(
   parameter int HIST_BITS = 8
) ();
   logic                 lookup_valid;
   logic [31:0]          lookup_pc;
   logic                 predict_hit;
   logic                 predict_taken;
   logic [HIST_BITS-1:0] predict_ghr;
   logic                 update_en;
   logic [31:0]          update_pc;
   logic [HIST_BITS-1:0] update_ghr;
   logic                 actual_taken;
   logic                 mispredict;

   modport master (
      output lookup_valid, lookup_pc, update_en, update_pc, update_ghr, actual_taken, mispredict,
      input  predict_hit, predict_taken, predict_ghr
   );

   modport slave (
      input  lookup_valid, lookup_pc, update_en, update_pc, update_ghr, actual_taken, mispredict,
      output predict_hit, predict_taken, predict_ghr
   );
endinterface

// File: rtl/gshare_assoc_predictor.sv
// Set-associative gshare direction predictor: combinational lookup, registered update,
// speculative global history with repair on mispredict.
module gshare_assoc_predictor #(
   parameter int ENTRY_NUM = 1024,
   parameter int WAYS      = 2,
   parameter int CTR_BITS  = 2,
   parameter int HIST_BITS = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   gshare_assoc_predictor_if.slave  bus
);

   localparam int SETS       = ENTRY_NUM / WAYS;
   localparam int INDEX_BITS = $clog2(SETS);
   localparam int TAG_BITS   = 32 - (INDEX_BITS + 2);
   localparam int WAY_BITS   = (WAYS > 1) ? $clog2(WAYS) : 1;

   localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
   localparam logic [CTR_BITS-1:0] CTR_WT   = CTR_BITS'(1) << (CTR_BITS - 1);
   localparam logic [CTR_BITS-1:0] CTR_WNT  = CTR_WT - CTR_BITS'(1);

   typedef logic [INDEX_BITS-1:0] index_t;
   typedef logic [TAG_BITS-1:0]   tag_t;
   typedef logic [WAY_BITS-1:0]   way_t;
   typedef logic [CTR_BITS-1:0]   ctr_t;
   typedef logic [HIST_BITS-1:0]  hist_t;

   logic  valid_q [SETS][WAYS];
   tag_t  tag_q   [SETS][WAYS];
   ctr_t  ctr_q   [SETS][WAYS];
   way_t  rr_q    [SETS];
   hist_t ghr_q;

   function automatic index_t set_index(input logic [31:0] pc, input hist_t hist);
      return pc[INDEX_BITS+1:2] ^ index_t'(hist);
   endfunction

   // ---------------- lookup (reads pre-update state, no bypass) ----------------
   index_t l_set;
   tag_t   l_tag;
   logic   l_hit;
   logic   l_taken;

   assign l_set = set_index(bus.lookup_pc, ghr_q);
   assign l_tag = bus.lookup_pc[31:INDEX_BITS+2];

   // NOTE: every variable in a combinational block gets a default first so no latch is inferred.
   always_comb begin
      l_hit   = 1'b0;
      l_taken = 1'b0;
      for (int w = 0; w < WAYS; w++) begin
         if (valid_q[l_set][w] && (tag_q[l_set][w] == l_tag)) begin
            l_hit   = 1'b1;
            l_taken = ctr_q[l_set][w][CTR_BITS-1];
         end
      end
   end

   assign bus.predict_hit   = l_hit;
   assign bus.predict_taken = l_taken;
   assign bus.predict_ghr   = ghr_q;

   // ---------------- update-side decode ----------------
   index_t u_set;
   tag_t   u_tag;
   logic   u_hit;
   way_t   u_hit_way;
   logic   inv_found;
   way_t   inv_way;
   way_t   victim;
   ctr_t   ctr_cur;
   ctr_t   ctr_next;
   way_t   rr_inc;
   hist_t  ghr_next;

   assign u_set = set_index(bus.update_pc, bus.update_ghr);
   assign u_tag = bus.update_pc[31:INDEX_BITS+2];

   always_comb begin
      u_hit     = 1'b0;
      u_hit_way = '0;
      inv_found = 1'b0;
      inv_way   = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (valid_q[u_set][w] && (tag_q[u_set][w] == u_tag)) begin
            u_hit     = 1'b1;
            u_hit_way = way_t'(w);
         end
         if (!valid_q[u_set][w] && !inv_found) begin
            inv_found = 1'b1;
            inv_way   = way_t'(w);
         end
      end
      victim = inv_found ? inv_way : rr_q[u_set];
   end

   always_comb begin
      ctr_cur  = ctr_q[u_set][u_hit_way];
      ctr_next = ctr_cur;
      if (bus.actual_taken && (ctr_cur != CTR_MAX))
         ctr_next = ctr_cur + CTR_BITS'(1);
      else if (!bus.actual_taken && (ctr_cur != '0))
         ctr_next = ctr_cur - CTR_BITS'(1);
   end

   assign rr_inc = (rr_q[u_set] == way_t'(WAYS - 1)) ? '0 : rr_q[u_set] + way_t'(1);

   // Repair beats speculation; the truncating cast also covers the one-bit history case.
   always_comb begin
      ghr_next = ghr_q;
      if (bus.update_en && bus.mispredict)
         ghr_next = hist_t'({bus.update_ghr, bus.actual_taken});
      else if (bus.lookup_valid)
         ghr_next = hist_t'({ghr_q, l_taken});
   end

   // ---------------- state ----------------
   // NOTE: the tables are flop arrays whose reset contents are architecturally visible, so
   // every entry is cleared; arrays that are RAM-backed must not be reset this way.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
               valid_q[s][w] <= 1'b0;
               tag_q[s][w]   <= '0;
               ctr_q[s][w]   <= CTR_WNT;
            end
            rr_q[s] <= '0;
         end
         ghr_q <= '0;
      end else begin
         if (bus.update_en) begin
            if (u_hit) begin
               ctr_q[u_set][u_hit_way] <= ctr_next;
            end else begin
               valid_q[u_set][victim] <= 1'b1;
               tag_q[u_set][victim]   <= u_tag;
               ctr_q[u_set][victim]   <= bus.actual_taken ? CTR_WT : CTR_WNT;
               if (!inv_found) rr_q[u_set] <= rr_inc;
            end
         end
         ghr_q <= ghr_next;
      end
   end

   // Byte-offset bits of the PCs never take part in indexing or tagging.
   logic unused_pc_bits;
   assign unused_pc_bits = ^{bus.lookup_pc[1:0], bus.update_pc[1:0]};

endmodule

// File: tb/tb_gshare_assoc_predictor.sv
// Self-checking bench for gshare_assoc_predictor at default parameters: directed vector
// table, hand-written GHR/aliasing/reset sequences, then random traffic against a model.
module tb_gshare_assoc_predictor;

   localparam int SETS = 512;
   localparam int WAYS = 2;
   localparam int HB   = 8;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   gshare_assoc_predictor_if #(.HIST_BITS(HB)) bus ();

   gshare_assoc_predictor #(
      .ENTRY_NUM(1024), .WAYS(WAYS), .CTR_BITS(2), .HIST_BITS(HB)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model: spec rules in plain integers ----------------
   int m_valid [SETS][WAYS];
   int m_tag   [SETS][WAYS];
   int m_ctr   [SETS][WAYS];
   int m_rr    [SETS];
   int m_ghr;

   function automatic int set_of(input logic [31:0] pc, input int hist);
      return ((int'(pc) >>> 2) & (SETS - 1)) ^ hist;
   endfunction

   function automatic int tag_of(input logic [31:0] pc);
      return int'(pc >> 11);
   endfunction

   task automatic model_lookup(input logic [31:0] pc, output bit hit, output bit taken);
      int s;
      s = set_of(pc, m_ghr);
      hit = 0;
      taken = 0;
      for (int w = 0; w < WAYS; w++)
         if (m_valid[s][w] != 0 && m_tag[s][w] == tag_of(pc)) begin
            hit = 1;
            taken = (m_ctr[s][w] >= 2);
         end
   endtask

   // Applies one clock edge worth of behaviour using the inputs the bench is driving.
   task automatic model_edge();
      bit ph, pt;
      int s, t, way, victim;
      if (!reset) begin
         for (int i = 0; i < SETS; i++) begin
            for (int w = 0; w < WAYS; w++) begin
               m_valid[i][w] = 0; m_tag[i][w] = 0; m_ctr[i][w] = 1;
            end
            m_rr[i] = 0;
         end
         m_ghr = 0;
         return;
      end
      model_lookup(bus.lookup_pc, ph, pt);
      if (bus.update_en) begin
         s = set_of(bus.update_pc, int'(bus.update_ghr));
         t = tag_of(bus.update_pc);
         way = -1;
         for (int w = 0; w < WAYS; w++)
            if (m_valid[s][w] != 0 && m_tag[s][w] == t) way = w;
         if (way >= 0) begin
            if (bus.actual_taken) m_ctr[s][way] = (m_ctr[s][way] == 3) ? 3 : m_ctr[s][way] + 1;
            else                  m_ctr[s][way] = (m_ctr[s][way] == 0) ? 0 : m_ctr[s][way] - 1;
         end else begin
            victim = -1;
            for (int w = WAYS - 1; w >= 0; w--)
               if (m_valid[s][w] == 0) victim = w;
            if (victim < 0) begin
               victim = m_rr[s];
               m_rr[s] = (m_rr[s] + 1) % WAYS;
            end
            m_valid[s][victim] = 1;
            m_tag[s][victim]   = t;
            m_ctr[s][victim]   = bus.actual_taken ? 2 : 1;
         end
      end
      if (bus.update_en && bus.mispredict)
         m_ghr = ((int'(bus.update_ghr) << 1) | int'(bus.actual_taken)) & ((1 << HB) - 1);
      else if (bus.lookup_valid)
         m_ghr = ((m_ghr << 1) | int'(pt)) & ((1 << HB) - 1);
   endtask

   // ---------------- drive / clock helpers ----------------
   task automatic drive(input bit rst, input bit lv, input logic [31:0] lpc, input bit ue,
                        input logic [31:0] upc, input logic [7:0] ughr, input bit at, input bit mp);
      reset            = rst;
      bus.lookup_valid = lv;
      bus.lookup_pc    = lpc;
      bus.update_en    = ue;
      bus.update_pc    = upc;
      bus.update_ghr   = ughr;
      bus.actual_taken = at;
      bus.mispredict   = mp;
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   // ---------------- directed vector table (GHR held at 0) ----------------
   typedef struct {
      string       name;
      bit          ue;
      logic [31:0] upc;
      bit          at;
      bit          mp;
      logic [31:0] lpc;
      bit          hit;
      bit          taken;
   } vec_t;

   vec_t vecs [14];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit eh, et;
      logic [31:0] pc_r;
      logic [31:0] miss_pcs [5];

      vecs[0]  = '{"alloc_taken",   1, 32'h1000, 1, 0, 32'h1000, 1, 1};
      vecs[1]  = '{"dec_to_1",      1, 32'h1000, 0, 0, 32'h1000, 1, 0};
      vecs[2]  = '{"dec_to_0",      1, 32'h1000, 0, 0, 32'h1000, 1, 0};
      vecs[3]  = '{"clamp_0",       1, 32'h1000, 0, 0, 32'h1000, 1, 0};
      vecs[4]  = '{"inc_to_1",      1, 32'h1000, 1, 0, 32'h1000, 1, 0};
      vecs[5]  = '{"alloc_b",       1, 32'h1800, 1, 0, 32'h1800, 1, 1};
      vecs[6]  = '{"a_still_hits",  0, 32'h0,    0, 0, 32'h1000, 1, 0};
      vecs[7]  = '{"alloc_c",       1, 32'h2000, 0, 0, 32'h2000, 1, 0};
      vecs[8]  = '{"a_evicted",     0, 32'h0,    0, 0, 32'h1000, 0, 0};
      vecs[9]  = '{"b_kept",        0, 32'h0,    0, 0, 32'h1800, 1, 1};
      vecs[10] = '{"alloc_d_rr1",   1, 32'h2800, 1, 0, 32'h1800, 0, 0};
      vecs[11] = '{"c_kept",        0, 32'h0,    0, 0, 32'h2000, 1, 0};
      vecs[12] = '{"d_hits",        0, 32'h0,    0, 0, 32'h2800, 1, 1};
      vecs[13] = '{"ue0_ignored",   0, 32'h3000, 1, 1, 32'h3000, 0, 0};

      miss_pcs[0] = 32'h1000; miss_pcs[1] = 32'h1800; miss_pcs[2] = 32'h2000;
      miss_pcs[3] = 32'h2800; miss_pcs[4] = 32'h4004;

      // Reset and first lookup.
      drive(0, 0, 32'h1000, 0, 0, 0, 0, 0);
      tick();
      tick();
      drive(1, 0, 32'h1000, 0, 0, 0, 0, 0);
      #1;
      check("reset_hit",   32'(bus.predict_hit),   0);
      check("reset_taken", 32'(bus.predict_taken), 0);
      check("reset_ghr",   32'(bus.predict_ghr),   0);

      foreach (vecs[i]) begin
         drive(1, 0, 32'h0, vecs[i].ue, vecs[i].upc, 8'h00, vecs[i].at, vecs[i].mp);
         tick();
         drive(1, 0, vecs[i].lpc, 0, 0, 0, 0, 0);
         #1;
         check({vecs[i].name, "_hit"},   32'(bus.predict_hit),   32'(vecs[i].hit));
         check({vecs[i].name, "_taken"}, 32'(bus.predict_taken), 32'(vecs[i].taken));
         check({vecs[i].name, "_ghr"},   32'(bus.predict_ghr),   0);
      end

      // Speculative GHR: 0x2800 predicts taken in set 0 and (after this update) set 1.
      drive(1, 0, 0, 1, 32'h2800, 8'h01, 1, 0);
      tick();
      drive(1, 1, 32'h2800, 0, 0, 0, 0, 0);
      #1;
      check("spec_ghr0", 32'(bus.predict_ghr), 32'h00);
      check("spec_tk0",  32'(bus.predict_taken), 1);
      tick();
      drive(1, 1, 32'h2800, 0, 0, 0, 0, 0);
      #1;
      check("spec_ghr1", 32'(bus.predict_ghr), 32'h01);
      check("spec_tk1",  32'(bus.predict_taken), 1);
      tick();
      drive(1, 1, 32'h2800, 1, 32'h2800, 8'h01, 0, 1);
      #1;
      check("spec_ghr3", 32'(bus.predict_ghr), 32'h03);
      tick();
      drive(1, 0, 32'h2800, 0, 0, 0, 0, 0);
      #1;
      check("repair_ghr", 32'(bus.predict_ghr), 32'h02);

      // Hash aliasing: 0x1000 trained under history 0x05 lives in set 5.
      drive(1, 0, 0, 1, 32'h1000, 8'h05, 1, 0);
      tick();
      drive(1, 0, 0, 1, 32'h4004, 8'h00, 0, 1);
      tick();
      drive(1, 0, 32'h1000, 0, 0, 0, 0, 0);
      #1;
      check("alias_ghr0", 32'(bus.predict_ghr), 32'h00);
      check("alias_miss", 32'(bus.predict_hit), 0);
      drive(1, 0, 0, 1, 32'h4004, 8'h02, 1, 1);
      tick();
      drive(1, 0, 32'h1000, 0, 0, 0, 0, 0);
      #1;
      check("alias_ghr5",  32'(bus.predict_ghr),   32'h05);
      check("alias_hit",   32'(bus.predict_hit),   1);
      check("alias_taken", 32'(bus.predict_taken), 1);

      // Mid-stream reset concurrent with an update that must be dropped.
      drive(0, 1, 32'h1000, 1, 32'h1000, 8'h00, 1, 1);
      tick();
      foreach (miss_pcs[i]) begin
         drive(1, 0, miss_pcs[i], 0, 0, 0, 0, 0);
         #1;
         check("rst_mid_hit", 32'(bus.predict_hit),   0);
         check("rst_mid_tk",  32'(bus.predict_taken), 0);
         check("rst_mid_ghr", 32'(bus.predict_ghr),   0);
      end

      // Random traffic from a small PC pool so sets fill, evict and saturate.
      for (int n = 0; n < 4000; n++) begin
         pc_r = (32'($urandom_range(0, 5)) << 11) | (32'($urandom_range(0, 7)) << 2);
         drive(($urandom_range(0, 149) != 0), 1'($urandom_range(0, 1)), pc_r,
               ($urandom_range(0, 3) != 0),
               (32'($urandom_range(0, 5)) << 11) | (32'($urandom_range(0, 7)) << 2),
               8'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 3) == 0));
         #1;
         model_lookup(pc_r, eh, et);
         check("rnd_hit",   32'(bus.predict_hit),   32'(eh));
         check("rnd_taken", 32'(bus.predict_taken), 32'(et));
         check("rnd_ghr",   32'(bus.predict_ghr),   32'(m_ghr));
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
